comp_seq_ctrl: RTL
==================

Name: comp_seq_ctrl

Overview:
Sequencing controller that compares two WIDTH-bit unsigned operands, most-significant digit first, by time-multiplexing one external 2-bit magnitude comparator slice. The slice is purely combinational.
- The controller drives the slice inputs with one 2-bit digit pair per cycle.
- It samples the slice's gt/eq/lt outputs and stops at the first unequal digit.
- It returns a registered result over a valid/ready handshake.

It sits between an operand source (start handshake) and a result consumer, and owns the slice exclusively.

Parameters:
- WIDTH, default 8: operand width in bits. Must be even and at least 2. Number of digits ND = WIDTH/2.
- CW, default $clog2(WIDTH/2)+1: width of cycles_used.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  operand pair offered.
- start_ready  output  1  controller can accept operands. High only in IDLE.
- op_a  input  WIDTH  operand A, sampled on start handshake.
- op_b  input  WIDTH  operand B, sampled on start handshake.
- slice_a_hi  output  1  A digit high bit to slice.
- slice_a_lo  output  1  A digit low bit to slice.
- slice_b_hi  output  1  B digit high bit to slice.
- slice_b_lo  output  1  B digit low bit to slice.
- slice_gt  input  1  slice result A digit > B digit.
- slice_eq  input  1  slice result, digits equal.
- slice_lt  input  1  slice result A digit < B digit.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_gt  output  1  A > B.
- res_eq  output  1  A == B.
- res_lt  output  1  A < B.
- res_err  output  1  slice returned a non-one-hot result.
- cycles_used  output  CW  number of COMPARE cycles spent on this result.

Behaviour:
- States: IDLE, COMPARE, DONE. Reset (rst=1 at an edge) forces IDLE from any state, including mid-COMPARE or DONE with res_valid high. Any pending result is discarded.
- Reset/IDLE values:
  - res_valid, res_gt, res_eq, res_lt, res_err = 0; cycles_used = 0.
  - All slice_* = 0; internal operand and digit-index registers = 0.
  - start_ready = 1 in IDLE. It is decoded from state, so it is 1 in the first cycle after reset is released.
- IDLE:
  - start_valid & start_ready at edge T: latch op_a/op_b, clear the digit index, clear res_* and cycles_used, go to COMPARE at T+1.
  - With start_valid=0, stay in IDLE.
- COMPARE, digit k (k=0 is the MSB digit):
  - Slice drive: slice_a_hi = A[WIDTH-1-2k], slice_a_lo = A[WIDTH-2-2k], and likewise for B. Driven combinationally from registers, so the value is stable for the whole cycle.
  - The slice result is sampled at the end of the same cycle, and cycles_used increments.
  - Exactly slice_gt: res_gt=1, go to DONE.
  - Exactly slice_lt: res_lt=1, go to DONE.
  - Exactly slice_eq and k<ND-1: k++, stay in COMPARE.
  - Exactly slice_eq and k=ND-1: res_eq=1, go to DONE.
  - Zero or more than one of gt/eq/lt asserted: res_err=1, res_gt/eq/lt=0, go to DONE.
  - start_ready=0 throughout COMPARE; start_valid is ignored.
- DONE:
  - res_valid=1; res_*, cycles_used and the slice_* outputs hold stable. slice_* are driven 0 in DONE.
  - res_valid & res_ready at an edge: go to IDLE. res_valid drops the next cycle.
  - No back-to-back bypass: a new start is accepted no earlier than the first IDLE cycle.
  - res_ready may be held high in advance; the handshake then completes on the first DONE cycle.
- Latency from start handshake at edge T:
  - First differing digit at index k: res_valid at T+k+2, cycles_used = k+1.
  - Equal operands: res_valid at T+ND+1, cycles_used = ND.
- Exactly one of res_gt/res_eq/res_lt/res_err is 1 whenever res_valid=1.
- Operands are unsigned. WIDTH=2 degenerates to a single COMPARE cycle.

Test Plan:
- Reset then idle: hold rst 3 cycles, then release. The first cycle after release must show start_ready=1, res_valid=0 and all slice_*=0.
- Early exit, WIDTH=8: A=8'hC5, B=8'h45. The top digit (3 vs 1) decides: res_gt=1, cycles_used=1, res_valid 2 cycles after the start edge. Slice drive in the COMPARE cycle is a_hi=1, a_lo=1, b_hi=0, b_lo=1.
- Full scan, equal: A=B=8'h9A gives 4 COMPARE cycles with digits 2,1,2,2 driven in order. Result res_eq=1, cycles_used=4, res_valid at T+5.
- Last-digit decision: A=8'h12, B=8'h13 gives res_lt=1 and cycles_used=4. Hold res_ready=0 for 5 cycles: outputs are stable and start_ready=0 throughout. Raising res_ready gives IDLE on the next cycle.
- Faulty slice: a bench model forces gt=eq=lt=0 on the second COMPARE cycle of A=8'h55, B=8'h56. Result res_err=1, res_gt/eq/lt=0, cycles_used=2.
- Reset mid-operation: start A=8'h00, B=8'h00 and assert rst during the 2nd COMPARE cycle. Next cycle is IDLE with res_valid=0 and no result is ever produced. A following start with A=8'hFF, B=8'h00 returns res_gt=1 with cycles_used=1.

Source files
------------

// File: rtl/comp_seq_ctrl_if.sv
// Bundles the start handshake, slice drive/sense and result handshake of comp_seq_ctrl.
// The controller connects through the slave modport; its environment uses master.
interface comp_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH / 2) + 1
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             slice_a_hi;
  logic             slice_a_lo;
  logic             slice_b_hi;
  logic             slice_b_lo;
  logic             slice_gt;
  logic             slice_eq;
  logic             slice_lt;
  logic             res_valid;
  logic             res_ready;
  logic             res_gt;
  logic             res_eq;
  logic             res_lt;
  logic             res_err;
  logic [CW-1:0]    cycles_used;

  modport master (
    output start_valid, op_a, op_b, slice_gt, slice_eq, slice_lt, res_ready,
    input  start_ready, slice_a_hi, slice_a_lo, slice_b_hi, slice_b_lo,
           res_valid, res_gt, res_eq, res_lt, res_err, cycles_used
  );

  modport slave (
    input  start_valid, op_a, op_b, slice_gt, slice_eq, slice_lt, res_ready,
    output start_ready, slice_a_hi, slice_a_lo, slice_b_hi, slice_b_lo,
           res_valid, res_gt, res_eq, res_lt, res_err, cycles_used
  );
endinterface

// File: rtl/comp_seq_ctrl.sv
// MSB-first magnitude compare of two WIDTH-bit operands using one shared
// combinational 2-bit comparator slice, one digit pair per cycle.
module comp_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH / 2) + 1
) (
  input  logic            clk,
  input  logic            rst,
  comp_seq_ctrl_if.slave  bus
);

  localparam int unsigned ND = WIDTH / 2;
  localparam int unsigned IW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [2:0]       slice_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

  // Operands shift left one digit per equal step, so the active digit is always the top two bits.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    err_d     = err_q;
    cyc_d     = cyc_q;
    slice_res = {bus.slice_gt, bus.slice_eq, bus.slice_lt};

    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          idx_d   = '0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          err_d   = 1'b0;
          cyc_d   = '0;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        cyc_d = cyc_q + CW'(1);
        case (slice_res)
          3'b100: begin
            gt_d    = 1'b1;
            valid_d = 1'b1;
            state_d = DONE;
          end
          3'b001: begin
            lt_d    = 1'b1;
            valid_d = 1'b1;
            state_d = DONE;
          end
          3'b010: begin
            if (idx_q == IW'(ND - 1)) begin
              eq_d    = 1'b1;
              valid_d = 1'b1;
              state_d = DONE;
            end else begin
              idx_d = idx_q + IW'(1);
              a_d   = a_q << 2;
              b_d   = b_q << 2;
            end
          end
          default: begin
            // Slice answer not one-hot: report it rather than guess an ordering.
            gt_d    = 1'b0;
            eq_d    = 1'b0;
            lt_d    = 1'b0;
            err_d   = 1'b1;
            valid_d = 1'b1;
            state_d = DONE;
          end
        endcase
      end

      DONE: begin
        if (bus.res_ready) begin
          valid_d = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          err_d   = 1'b0;
          cyc_d   = '0;
          a_d     = '0;
          b_d     = '0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.slice_a_hi  = (state_q == COMPARE) & a_q[WIDTH-1];
  assign bus.slice_a_lo  = (state_q == COMPARE) & a_q[WIDTH-2];
  assign bus.slice_b_hi  = (state_q == COMPARE) & b_q[WIDTH-1];
  assign bus.slice_b_lo  = (state_q == COMPARE) & b_q[WIDTH-2];
  assign bus.res_valid   = valid_q;
  assign bus.res_gt      = gt_q;
  assign bus.res_eq      = eq_q;
  assign bus.res_lt      = lt_q;
  assign bus.res_err     = err_q;
  assign bus.cycles_used = cyc_q;

endmodule
